// File: rtl/dvd_pkg.sv
// Shared types and constants for the bouncing-box pixel stage.
package dvd_pkg;

    localparam int unsigned COLOUR_W    = 6;
    localparam int unsigned CIDX_W      = 3;
    localparam int unsigned NUM_COLOURS = 6;

    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [CIDX_W-1:0]   cidx_t;

    // Direction of travel along one axis
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam colour_t WHITE = 6'b111111;

    // Entry 0 is the rightmost element: red, yellow, green, cyan, blue, magenta
    localparam logic [NUM_COLOURS-1:0][COLOUR_W-1:0] PALETTE = {
        6'b110011,
        6'b000011,
        6'b001111,
        6'b001100,
        6'b111100,
        6'b110000
    };

endpackage

// File: rtl/dvd_axis.sv
// One axis of box motion: steps SPEED per frame tick, reflecting at 0 and LIMIT.
module dvd_axis
    import dvd_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned LIMIT = 36,
    parameter int unsigned SPEED = 1,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             pause,
    output logic [WIDTH-1:0] pos,
    output dir_t             dir,
    output logic             reflect_c
);

    localparam logic [WIDTH:0] LIMIT_W = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0] SPEED_W = (WIDTH+1)'(SPEED);

    logic [WIDTH-1:0] pos_q, pos_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH:0]   pos_w;
    logic [WIDTH:0]   sum_w;
    logic             hit;
    logic             step;

    assign step  = tick & ~pause;
    assign pos_w = {1'b0, pos_q};
    assign sum_w = pos_w + SPEED_W;

    // Next position with clamping at either edge; sum is one bit wider so it never wraps
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        hit   = 1'b0;
        if (dir_q == DIR_POS) begin
            if (sum_w >= LIMIT_W) begin
                pos_d = WIDTH'(LIMIT);
                dir_d = DIR_NEG;
                hit   = 1'b1;
            end else begin
                pos_d = sum_w[WIDTH-1:0];
            end
        end else begin
            if (pos_w <= SPEED_W) begin
                pos_d = '0;
                dir_d = DIR_POS;
                hit   = 1'b1;
            end else begin
                pos_d = pos_q - WIDTH'(SPEED);
            end
        end
    end

    // Position/direction register, advances only on an unpaused tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= WIDTH'(INIT);
            dir_q <= DIR_POS;
        end else if (step) begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign reflect_c = step & hit;

endmodule

// File: rtl/dvd_bouncer.sv
// Bouncing-box pixel colour stage behind the VGA sync generator.
// Optional build macro: DVD_CORNER_FLASH_EN (white flash after a corner hit).
module dvd_bouncer
    import dvd_pkg::*;
#(
    parameter int unsigned H_DISPLAY    = 40,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned BOX_W        = 4,
    parameter int unsigned BOX_H        = 48,
    parameter int unsigned SPEED_X      = 1,
    parameter int unsigned SPEED_Y      = 8,
    parameter int unsigned X_INIT       = 0,
    parameter int unsigned Y_INIT       = 0,
    parameter int unsigned FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       vsync,
    input  logic       pause,
    output logic [5:0] rgb,
    output logic       bounce,
    output logic       corner
);

    localparam int unsigned X_MAX = H_DISPLAY - BOX_W;
    localparam int unsigned Y_MAX = V_DISPLAY - BOX_H;

    logic       vsync_q;
    logic       tick;
    logic [5:0] x_pos;
    logic [9:0] y_pos;
    dir_t       x_dir, y_dir;
    logic       x_reflect, y_reflect;
    logic       any_reflect;
    cidx_t      cidx_q, cidx_d;
    colour_t    rgb_q, rgb_d;
    colour_t    box_colour;
    logic       bounce_q, corner_q;
    logic       in_box;
    logic [6:0] h_w, x_w;
    logic [10:0] v_w, y_w;

    assign tick        = vsync & ~vsync_q;
    assign any_reflect = x_reflect | y_reflect;

    dvd_axis #(.WIDTH(6), .LIMIT(X_MAX), .SPEED(SPEED_X), .INIT(X_INIT)) u_axis_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .pause     (pause),
        .pos       (x_pos),
        .dir       (x_dir),
        .reflect_c (x_reflect)
    );

    dvd_axis #(.WIDTH(10), .LIMIT(Y_MAX), .SPEED(SPEED_Y), .INIT(Y_INIT)) u_axis_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .pause     (pause),
        .pos       (y_pos),
        .dir       (y_dir),
        .reflect_c (y_reflect)
    );

`ifdef DVD_CORNER_FLASH_EN
    localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);
    logic [FLASH_W-1:0] flash_q, flash_d;

    // Corner hit reloads the flash counter; it otherwise counts frames down to zero
    always_comb begin
        flash_d = flash_q;
        if (x_reflect & y_reflect) begin
            flash_d = FLASH_W'(FLASH_FRAMES);
        end else if (tick && (flash_q != '0)) begin
            flash_d = flash_q - FLASH_W'(1);
        end
    end

    // Flash counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flash_q <= '0;
        else        flash_q <= flash_d;
    end

    assign box_colour = (flash_q != '0) ? WHITE : PALETTE[cidx_q];
`else
    assign box_colour = PALETTE[cidx_q];
`endif

    // Widened box compares so x+BOX_W / y+BOX_H cannot wrap
    always_comb begin
        h_w    = {1'b0, hpos};
        x_w    = {1'b0, x_pos};
        v_w    = {1'b0, vpos};
        y_w    = {1'b0, y_pos};
        in_box = display_on
               & (h_w >= x_w) & (h_w < x_w + 7'(BOX_W))
               & (v_w >= y_w) & (v_w < y_w + 11'(BOX_H));
        rgb_d  = in_box ? box_colour : '0;
        cidx_d = cidx_q;
        if (any_reflect) begin
            cidx_d = (cidx_q == cidx_t'(NUM_COLOURS - 1)) ? '0 : cidx_q + cidx_t'(1);
        end
    end

    // Output, colour index and vsync edge registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b1;
            rgb_q    <= '0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            cidx_q   <= '0;
        end else begin
            vsync_q  <= vsync;
            rgb_q    <= rgb_d;
            bounce_q <= any_reflect;
            corner_q <= x_reflect & y_reflect;
            cidx_q   <= cidx_d;
        end
    end

    assign rgb    = rgb_q;
    assign bounce = bounce_q;
    assign corner = corner_q;

endmodule

// File: tb/tb_dvd_bouncer.sv
// Randomized scoreboard bench for dvd_bouncer against a behavioural model.
module tb_dvd_bouncer;

    localparam int H_DISP = 40;
    localparam int V_DISP = 480;
    localparam int BW     = 4;
    localparam int BH     = 48;
    localparam int SX     = 1;
    localparam int SY     = 8;
    localparam int FLASHN = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       vsync = 1'b1;
    logic       pause = 1'b0;
    logic [5:0] rgb;
    logic       bounce;
    logic       corner;

    dvd_bouncer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .vsync      (vsync),
        .pause      (pause),
        .rgb        (rgb),
        .bounce     (bounce),
        .corner     (corner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] rgb;
        logic       bounce;
        logic       corner;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   sb_on    = 1'b0;
    int   frame_cnt = 0;
    int   bounce_frames[$];
    int   corner_frames[$];

    // Behavioural model state: position, signed velocity, colour, flash frames left
    int m_x, m_y, m_vx, m_vy, m_col, m_flash;
    bit m_vprev;

    function automatic logic [5:0] pal(input int i);
        case (i)
            0: return 6'b110000;
            1: return 6'b111100;
            2: return 6'b001100;
            3: return 6'b001111;
            4: return 6'b000011;
            default: return 6'b110011;
        endcase
    endfunction

    // Move one axis by its velocity, clamping to [0, maxv] and reversing on contact
    function automatic bit move(inout int p, inout int v, input int maxv);
        int n;
        n = p + v;
        if (n >= maxv) begin
            p = maxv; v = -v; return 1'b1;
        end else if (n <= 0) begin
            p = 0; v = -v; return 1'b1;
        end
        p = n;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vx = SX; m_vy = SY;
        m_col = 0; m_flash = 0; m_vprev = 1'b1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one pixel cycle and push the response the DUT must present after the edge
    task automatic drive(input bit don, input int h, input int v, input bit vs, input bit pz);
        exp_t e;
        bit   in_box, tk, rx, ry;
        @(negedge clk);
        display_on = don; hpos = 6'(h); vpos = 10'(v); vsync = vs; pause = pz;
        in_box = don && (h >= m_x) && (h < m_x + BW) && (v >= m_y) && (v < m_y + BH);
        e.rgb = 6'b0;
        if (in_box) e.rgb = (m_flash > 0) ? 6'b111111 : pal(m_col);
        tk = vs && !m_vprev;
        rx = 1'b0; ry = 1'b0;
        if (tk) frame_cnt++;
        if (tk && !pz) begin
            rx = move(m_x, m_vx, H_DISP - BW);
            ry = move(m_y, m_vy, V_DISP - BH);
        end
        e.bounce = rx | ry;
        e.corner = rx & ry;
        if (rx | ry) m_col = (m_col + 1) % 6;
`ifdef DVD_CORNER_FLASH_EN
        if (rx & ry) m_flash = FLASHN;
        else if (tk && m_flash > 0) m_flash--;
`endif
        m_vprev = vs;
        exp_q.push_back(e);
    endtask

    // One compressed frame: pixel samples (random and near box edges), then vsync
    task automatic frame(input bit pz);
        for (int i = 0; i < 12; i++) begin
            int h, v;
            bit don;
            if (i % 2 == 0) begin
                h = $urandom_range(63); v = $urandom_range(V_DISP - 1);
            end else begin
                h = m_x - 1 + $urandom_range(BW + 1);
                v = m_y - 1 + $urandom_range(2) * (BH / 2) + $urandom_range(1);
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end
            don = (h < H_DISP) && ($urandom_range(7) != 0);
            drive(don, h, v, 1'b0, pz);
        end
        drive(1'b0, 0, V_DISP + 10, 1'b1, pz);
        drive(1'b0, 0, V_DISP + 11, 1'b1, pz);
        drive(1'b0, 0, V_DISP + 12, 1'b0, pz);
    endtask

    // Monitor: every presented output cycle is compared to the oldest expectation
    always @(posedge clk) begin
        #1;
        if (sb_on && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rgb", int'(rgb), int'(e.rgb));
            check("bounce", int'(bounce), int'(e.bounce));
            check("corner", int'(corner), int'(e.corner));
            if (bounce && frame_cnt <= 108) bounce_frames.push_back(frame_cnt);
            if (corner && frame_cnt <= 108) corner_frames.push_back(frame_cnt);
        end
    end

    initial begin
        int exp_b[4];
        exp_b = '{36, 54, 72, 108};
        model_reset();
        // Reset held mid-frame with vsync high
        repeat (3) @(negedge clk);
        display_on = 1'b1; hpos = 6'd1; vpos = 10'd1;
        #1;
        check("reset_rgb", int'(rgb), 0);
        check("reset_bounce", int'(bounce), 0);
        check("reset_corner", int'(corner), 0);
        @(negedge clk);
        display_on = 1'b0;
        rst_n = 1'b1;
        sb_on = 1'b1;
        // vsync stays high across release: no tick, box still at origin
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        drive(1'b1, 0, 0, 1'b1, 1'b0);
        drive(1'b1, 3, 47, 1'b1, 1'b0);
        drive(1'b1, 4, 0, 1'b1, 1'b0);
        drive(1'b1, 0, 48, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        // 108 unpaused frames reach the top-right corner
        for (int f = 0; f < 108; f++) frame(1'b0);
        drive(1'b1, 36, 0, 1'b0, 1'b0);
        drive(1'b1, 39, 47, 1'b0, 1'b0);
        drive(1'b1, 35, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("bounce_count_108", bounce_frames.size(), 4);
        for (int i = 0; i < 4 && i < bounce_frames.size(); i++)
            check("bounce_frame", bounce_frames[i], exp_b[i]);
        check("corner_count_108", corner_frames.size(), 1);
        if (corner_frames.size() > 0) check("corner_frame", corner_frames[0], 108);
        // Held motion through five paused frames, then resume
        for (int f = 0; f < 5; f++) frame(1'b1);
        for (int f = 0; f < 40; f++) frame(1'b0);
        // Random pause mix
        for (int f = 0; f < 150; f++) frame($urandom_range(3) == 0);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvd_bouncer.md
Name: dvd_bouncer

Overview:
Pixel-colour stage directly downstream of the VGA sync generator. It consumes hpos/vpos/display_on/vsync and moves a solid box across the 40x480 active area once per frame, reflecting off the edges. The box colour advances on every bounce. It emits registered 6-bit RGB (2 bits per channel) aligned with the generator's registered hsync/vsync.

Parameters:
H_DISPLAY, 40, active columns (hpos units)
V_DISPLAY, 480, active lines
BOX_W, 4, box width in columns; must be < H_DISPLAY
BOX_H, 48, box height in lines; must be < V_DISPLAY
SPEED_X, 1, columns moved per frame; 1..H_DISPLAY-BOX_W
SPEED_Y, 8, lines moved per frame; 1..V_DISPLAY-BOX_H
X_INIT, 0, reset x position (0..H_DISPLAY-BOX_W)
Y_INIT, 0, reset y position (0..V_DISPLAY-BOX_H)
FLASH_FRAMES, 32, corner-flash length in frames (only with the optional feature)

Ports:
clk  in  1  pixel clock, same as the sync generator
rst_n  in  1  asynchronous active-low reset
hpos  in  6  current column from the sync generator
vpos  in  10  current line from the sync generator
display_on  in  1  active-area flag from the sync generator
vsync  in  1  registered vsync from the sync generator
pause  in  1  1 = freeze motion; rendering continues
rgb  out  6  {R1,R0,G1,G0,B1,B0}, registered
bounce  out  1  1-cycle pulse when either axis reflects
corner  out  1  1-cycle pulse when both axes reflect on the same frame

Behaviour:
- Reset is async on rst_n low and releases synchronously at the next clk.
- Reset values:
  - rgb = 0, bounce = 0, corner = 0
  - x = X_INIT, y = Y_INIT, dx = +, dy = +
  - colour index = 0
  - vsync_q = 1, so a high vsync at release produces no tick.
- Frame tick: tick = vsync & ~vsync_q, which fires exactly one cycle per frame. Motion updates on the tick cycle, and the new position is valid the next cycle. Because the tick falls in vertical sync, the update is never visible mid-frame.
- If pause = 1 on the tick cycle, x, y, dx, dy and colour hold, and no pulses are emitted.
- Axis update (x shown; y is identical using V_DISPLAY, BOX_H, SPEED_Y). Let MAX = H_DISPLAY - BOX_W.
  - dx = + and x + SPEED_X >= MAX: x <= MAX, dx <= -, reflect.
  - dx = - and x <= SPEED_X: x <= 0, dx <= +, reflect.
  - Otherwise x <= x ± SPEED_X.
  - Compute the sum one bit wider than x. No wrap-around is permitted.
- bounce = reflect_x | reflect_y, registered and asserted for the cycle after the tick.
- corner = reflect_x & reflect_y, same timing.
- Colour index is 0..5 and increments once per tick with bounce, even if both axes reflect. It wraps 5 -> 0.
- Palette (from the package):
  - 0 = 110000 red
  - 1 = 111100 yellow
  - 2 = 001100 green
  - 3 = 001111 cyan
  - 4 = 000011 blue
  - 5 = 110011 magenta
- Render: in_box = display_on & (hpos >= x) & (hpos < x+BOX_W) & (vpos >= y) & (vpos < y+BOX_H). Use widened compares.
- rgb <= in_box ? palette[colour] : 0. Latency is 1 cycle from hpos/vpos, which matches the generator's registered hsync/vsync.
- Outside display_on, rgb = 0 unconditionally.

Optional Feature:
Macro: DVD_CORNER_FLASH_EN.
- Defined: a corner event loads a frame counter with FLASH_FRAMES, which decrements on each tick.
  - While the counter is nonzero, box pixels render 111111 in place of the palette colour.
  - A new corner event while flashing reloads the counter.
  - The counter resets to 0.
- Undefined: no counter is built, and corner affects only the corner pulse.

Decomposition:
- Package dvd_pkg holds:
  - 6-bit colour type
  - 3-bit colour index type
  - PALETTE constant array (6 entries)
  - NUM_COLOURS = 6
  - WHITE = 6'b111111
- Sub-module dvd_axis is parameterised by WIDTH, LIMIT, SPEED and INIT, with inputs tick and pause and outputs pos, dir and reflect. It is instantiated twice: x with WIDTH 6, y with WIDTH 10.

Test Plan:
1. Reset mid-frame with vsync = 1, then release and hold vsync high -> no tick, x = 0, y = 0, rgb = 0, colour = 0.
2. Run 36 ticks with default parameters -> x = 36, dx = -, bounce pulses once at tick 36, colour = 1; y = 288 and still moving down.
3. Run 108 ticks from reset -> corner pulses at tick 108 with x = 36, y = 0 (top-right). Bounce pulses occur at ticks 36, 54, 72 and 108, and colour = 4 after tick 108.
4. With box at x = 10, y = 100, sweep hpos/vpos -> rgb = palette colour exactly for hpos 10..13 and vpos 100..147, one cycle after the inputs. rgb = 0 at hpos 14, vpos 148, and whenever display_on = 0.
5. Hold pause through 5 ticks -> x, y, colour and direction unchanged and no pulses. Release pause -> motion resumes from the held state.
6. With DVD_CORNER_FLASH_EN, reach the tick-108 corner -> box renders 111111 for the next 32 frames, then returns to the palette colour.
